lock_chamber_ctrl: RTL

Parametrised canal-lock chamber sequencer that replaces the single-cycle gate toggler with a full fill/drain/gate-dwell state machine. It latches boat requests from the upper and lower sides, moves an internal water-level model between configurable low and high levels, and opens exactly one gate at a time. It sits between the switch/sensor debouncers and the gate/valve drivers and display logic of the lock system.

---
 rtl/lock_chamber_ctrl.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/lock_chamber_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : lock_chamber_ctrl
// Description : Canal-lock chamber sequencer. Latches boat requests from the
//               upper and lower sides and models the chamber water level
//               between LEVEL_LOW and LEVEL_HIGH. It runs the fill/drain
//               valves and opens one gate at a time, with a minimum open
//               dwell and a fixed closing time.
// Ports       : clk, reset (sync, active-high)
//               upper_switch / lower_switch  - side requests (pulse or level)
//               occupied                     - boat-in-chamber sense
//               estop                        - freeze input (LOCK_ESTOP_EN only)
//               gate_state   [1:0]           - 00 closed, 01 upper, 10 lower
//               water_status [1:0]           - 10 low, 11 high, 01 fill, 00 drain
//               level [LEVEL_W-1:0]          - modelled water level
//               fill_valve, drain_valve, busy
// Config      : define LOCK_ESTOP_EN to add the estop freeze input.
// Revision    : 1.0 - initial release
// ============================================================================
module lock_chamber_ctrl #(
    parameter int LEVEL_W     = 8,
    parameter int LEVEL_LOW   = 10,
    parameter int LEVEL_HIGH  = 200,
    parameter int RATE        = 1,
    parameter int GATE_CYCLES = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               upper_switch,
    input  logic               lower_switch,
    input  logic               occupied,
`ifdef LOCK_ESTOP_EN
    input  logic               estop,
`endif
    output logic [1:0]         gate_state,
    output logic [1:0]         water_status,
    output logic [LEVEL_W-1:0] level,
    output logic               fill_valve,
    output logic               drain_valve,
    output logic               busy
);

    localparam int TMR_W = (GATE_CYCLES < 2) ? 1 : $clog2(GATE_CYCLES);
    localparam logic [TMR_W-1:0]   TMR_LOAD = TMR_W'(GATE_CYCLES - 1);
    localparam logic [LEVEL_W-1:0] LVL_LO   = LEVEL_W'(LEVEL_LOW);
    localparam logic [LEVEL_W-1:0] LVL_HI   = LEVEL_W'(LEVEL_HIGH);
    localparam logic [31:0]        LO_U     = 32'(LEVEL_LOW);
    localparam logic [31:0]        HI_U     = 32'(LEVEL_HIGH);
    localparam logic [31:0]        RATE_U   = 32'(RATE);

    localparam logic [2:0] S_CLOSED  = 3'd0;
    localparam logic [2:0] S_FILL    = 3'd1;
    localparam logic [2:0] S_DRAIN   = 3'd2;
    localparam logic [2:0] S_OPEN_UP = 3'd3;
    localparam logic [2:0] S_OPEN_LO = 3'd4;
    localparam logic [2:0] S_CLOSING = 3'd5;

    logic [2:0]         state_q,  state_d;
    logic [LEVEL_W-1:0] level_q,  level_d;
    logic [TMR_W-1:0]   timer_q,  timer_d;
    logic               req_up_q, req_up_d;
    logic               req_lo_q, req_lo_d;

    logic               w_estop;
    logic               w_enter_up;
    logic               w_enter_lo;
    logic [31:0]        w_lvl32;
    logic [LEVEL_W-1:0] w_fill_next;
    logic [LEVEL_W-1:0] w_drain_next;
    logic               w_at_low;
    logic               w_at_high;

`ifdef LOCK_ESTOP_EN
    assign w_estop = estop;
`else
    assign w_estop = 1'b0;
`endif

    // occupied is sampled for the interface but has no behavioural effect.
    logic unused_occupied;
    assign unused_occupied = occupied;

    assign w_at_low  = (level_q == LVL_LO);
    assign w_at_high = (level_q == LVL_HI);

    // Clamp comparisons are done in 32 bits so neither the add nor the
    // subtract can wrap around the level register.
    assign w_lvl32      = 32'(level_q);
    assign w_fill_next  = (w_lvl32 + RATE_U >= HI_U) ? LVL_HI
                                                     : level_q + LEVEL_W'(RATE);
    assign w_drain_next = (w_lvl32 < LO_U + RATE_U)  ? LVL_LO
                                                     : level_q - LEVEL_W'(RATE);

    always_comb begin
        state_d    = state_q;
        level_d    = level_q;
        timer_d    = timer_q;
        w_enter_up = 1'b0;
        w_enter_lo = 1'b0;
        case (state_q)
            S_CLOSED: begin
                // A request matching the current level wins over a transit.
                if (w_at_high && req_up_q) begin
                    state_d    = S_OPEN_UP;
                    timer_d    = TMR_LOAD;
                    w_enter_up = 1'b1;
                end else if (w_at_low && req_lo_q) begin
                    state_d    = S_OPEN_LO;
                    timer_d    = TMR_LOAD;
                    w_enter_lo = 1'b1;
                end else if (w_at_low && req_up_q) begin
                    state_d = S_FILL;
                end else if (w_at_high && req_lo_q) begin
                    state_d = S_DRAIN;
                end
            end
            S_FILL: begin
                level_d = w_fill_next;
                if (w_fill_next == LVL_HI) begin
                    state_d    = S_OPEN_UP;
                    timer_d    = TMR_LOAD;
                    w_enter_up = 1'b1;
                end
            end
            S_DRAIN: begin
                level_d = w_drain_next;
                if (w_drain_next == LVL_LO) begin
                    state_d    = S_OPEN_LO;
                    timer_d    = TMR_LOAD;
                    w_enter_lo = 1'b1;
                end
            end
            S_OPEN_UP: begin
                if (timer_q != '0) begin
                    timer_d = timer_q - 1'b1;
                end else if (!upper_switch) begin
                    state_d = S_CLOSING;
                    timer_d = TMR_LOAD;
                end
            end
            S_OPEN_LO: begin
                if (timer_q != '0) begin
                    timer_d = timer_q - 1'b1;
                end else if (!lower_switch) begin
                    state_d = S_CLOSING;
                    timer_d = TMR_LOAD;
                end
            end
            S_CLOSING: begin
                if (timer_q != '0) begin
                    timer_d = timer_q - 1'b1;
                end else begin
                    state_d = S_CLOSED;
                end
            end
            default: begin
                state_d = S_CLOSED;
            end
        endcase

        // Emergency stop freezes the sequencer but not the request latches.
        if (w_estop) begin
            state_d    = state_q;
            level_d    = level_q;
            timer_d    = timer_q;
            w_enter_up = 1'b0;
            w_enter_lo = 1'b0;
        end
    end

    // A switch still high on the clearing cycle re-arms its latch.
    assign req_up_d = upper_switch | (req_up_q & ~w_enter_up);
    assign req_lo_d = lower_switch | (req_lo_q & ~w_enter_lo);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_CLOSED;
            level_q  <= LVL_LO;
            timer_q  <= '0;
            req_up_q <= 1'b0;
            req_lo_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            level_q  <= level_d;
            timer_q  <= timer_d;
            req_up_q <= req_up_d;
            req_lo_q <= req_lo_d;
        end
    end

    assign level       = level_q;
    assign gate_state  = (state_q == S_OPEN_UP) ? 2'b01 :
                         (state_q == S_OPEN_LO) ? 2'b10 : 2'b00;
    assign water_status = (state_q == S_FILL)  ? 2'b01 :
                          (state_q == S_DRAIN) ? 2'b00 :
                          w_at_high            ? 2'b11 : 2'b10;
    assign fill_valve  = (state_q == S_FILL)  && !w_estop;
    assign drain_valve = (state_q == S_DRAIN) && !w_estop;
    assign busy        = (state_q != S_CLOSED) || w_estop;

endmodule
`default_nettype wire
